cart_bus_initiator: RTL and testbench

- Master side of the internal cart register bus: request / write / busy / ack / 11-bit address / 32-bit data.
- Accepts one command at a time from an upstream agent (PI bridge or MCU link) over a valid/ready port.
- Drives the bus request and holds it until the target is not busy; for reads, waits for the target's ack and captures read data.
- Returns a one-cycle response pulse; an optional timeout flags reads that are never acked.

---
 rtl/cart_bus_pkg.sv | 15 +
 rtl/cart_bus_initiator.sv | 163 ++++++++++++++++
 tb/tb_cart_bus_initiator.sv | 221 ++++++++++++++++++++++
 3 files changed

// File: rtl/cart_bus_pkg.sv
// Shared widths, FSM state encoding and default error word for the cart register bus initiator.
package cart_bus_pkg;

    localparam int CART_BUS_ADDR_W = 11;
    localparam int CART_BUS_DATA_W = 32;
    localparam logic [CART_BUS_DATA_W-1:0] CART_BUS_ERROR_DATA = 32'hFFFF_FFFF;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        REQ      = 2'd1,
        WAIT_ACK = 2'd2,
        RESP     = 2'd3
    } cart_bus_state_e;

endpackage

// File: rtl/cart_bus_initiator.sv
// Cart register bus master: takes one upstream command, runs the request/busy/ack handshake, returns a response pulse.
// Optional read timeout is built only when CART_BUS_TIMEOUT_EN is defined.
module cart_bus_initiator
    import cart_bus_pkg::*;
#(
    parameter int                         TIMEOUT_CYCLES = 255,
    parameter logic [CART_BUS_DATA_W-1:0] ERROR_DATA     = CART_BUS_ERROR_DATA
) (
    input  logic                       i_clk,
    input  logic                       i_reset_n,
    input  logic                       i_cmd_valid,
    output logic                       o_cmd_ready,
    input  logic                       i_cmd_write,
    input  logic [CART_BUS_ADDR_W-1:0] i_cmd_address,
    input  logic [CART_BUS_DATA_W-1:0] i_cmd_data,
    output logic                       o_rsp_valid,
    output logic [CART_BUS_DATA_W-1:0] o_rsp_data,
    output logic                       o_rsp_error,
    output logic                       o_request,
    output logic                       o_write,
    input  logic                       i_busy,
    input  logic                       i_ack,
    output logic [CART_BUS_ADDR_W-1:0] o_address,
    output logic [CART_BUS_DATA_W-1:0] o_data,
    input  logic [CART_BUS_DATA_W-1:0] i_data
);

    cart_bus_state_e state_r, state_s;

    logic                       cmd_ready_s;
    logic                       request_s;
    logic                       write_s;
    logic [CART_BUS_ADDR_W-1:0] address_s;
    logic [CART_BUS_DATA_W-1:0] data_s;
    logic                       rsp_valid_s;
    logic [CART_BUS_DATA_W-1:0] rsp_data_s;
    logic                       rsp_error_s;
    logic                       accept_s;
    logic                       timeout_s;

    assign accept_s = i_cmd_valid && o_cmd_ready;

`ifdef CART_BUS_TIMEOUT_EN
    localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [CNT_W-1:0] cnt_r, cnt_s;

    // Timeout fires on the last WAIT_ACK cycle, so the read waits exactly TIMEOUT_CYCLES cycles for ack.
    assign timeout_s = (cnt_r == CNT_W'(TIMEOUT_CYCLES - 1));

    // Timeout counter register.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            cnt_r <= '0;
        end else begin
            cnt_r <= cnt_s;
        end
    end
`else
    assign timeout_s = 1'b0;
`endif

    // State and registered outputs.
    always_ff @(posedge i_clk or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state_r     <= IDLE;
            o_cmd_ready <= 1'b0;
            o_request   <= 1'b0;
            o_write     <= 1'b0;
            o_address   <= '0;
            o_data      <= '0;
            o_rsp_valid <= 1'b0;
            o_rsp_data  <= '0;
            o_rsp_error <= 1'b0;
        end else begin
            state_r     <= state_s;
            o_cmd_ready <= cmd_ready_s;
            o_request   <= request_s;
            o_write     <= write_s;
            o_address   <= address_s;
            o_data      <= data_s;
            o_rsp_valid <= rsp_valid_s;
            o_rsp_data  <= rsp_data_s;
            o_rsp_error <= rsp_error_s;
        end
    end

    // Next-state logic; ack takes priority over timeout.
    always_comb begin
        state_s = state_r;
        case (state_r)
            IDLE:     if (accept_s) state_s = REQ; else state_s = IDLE;
            REQ:      if (!i_busy) state_s = o_write ? RESP : WAIT_ACK; else state_s = REQ;
            WAIT_ACK: if (i_ack || timeout_s) state_s = RESP; else state_s = WAIT_ACK;
            RESP:     state_s = IDLE;
            default:  state_s = IDLE;
        endcase
    end

    // Next values for the registered outputs; bus outputs hold unless explicitly changed.
    always_comb begin
        cmd_ready_s = (state_s == IDLE);
        request_s   = o_request;
        write_s     = o_write;
        address_s   = o_address;
        data_s      = o_data;
        rsp_valid_s = 1'b0;
        rsp_data_s  = o_rsp_data;
        rsp_error_s = 1'b0;
`ifdef CART_BUS_TIMEOUT_EN
        cnt_s       = cnt_r;
`endif
        case (state_r)
            IDLE: begin
                if (accept_s) begin
                    request_s = 1'b1;
                    write_s   = i_cmd_write;
                    address_s = i_cmd_address;
                    data_s    = i_cmd_data;
                end else begin
                    request_s = 1'b0;
                end
            end
            REQ: begin
                if (!i_busy) begin
                    request_s = 1'b0;
                    if (o_write) begin
                        rsp_valid_s = 1'b1;
                        rsp_data_s  = '0;
                    end else begin
`ifdef CART_BUS_TIMEOUT_EN
                        cnt_s = '0;
`endif
                        rsp_valid_s = 1'b0;
                    end
                end else begin
                    request_s = 1'b1;
                end
            end
            WAIT_ACK: begin
                if (i_ack) begin
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = i_data;
                end else if (timeout_s) begin
                    rsp_valid_s = 1'b1;
                    rsp_data_s  = ERROR_DATA;
                    rsp_error_s = 1'b1;
                end else begin
`ifdef CART_BUS_TIMEOUT_EN
                    cnt_s = cnt_r + CNT_W'(1);
`endif
                    rsp_valid_s = 1'b0;
                end
            end
            RESP: begin
                request_s = 1'b0;
            end
            default: begin
                request_s = 1'b0;
            end
        endcase
    end

endmodule

// File: tb/tb_cart_bus_initiator.sv
// Self-checking bench for cart_bus_initiator: a scripted target plus a latency/result model derived from the bus rules.
module tb_cart_bus_initiator;

`ifdef CART_BUS_TIMEOUT_EN
    localparam bit TMO_EN = 1'b1;
`else
    localparam bit TMO_EN = 1'b0;
`endif
    localparam int TMO = 8;
    localparam logic [31:0] ERR_WORD = 32'hFFFF_FFFF;

    logic        i_clk = 1'b0;
    logic        i_reset_n = 1'b0;
    logic        i_cmd_valid = 1'b0;
    logic        o_cmd_ready;
    logic        i_cmd_write = 1'b0;
    logic [10:0] i_cmd_address = 11'd0;
    logic [31:0] i_cmd_data = 32'd0;
    logic        o_rsp_valid;
    logic [31:0] o_rsp_data;
    logic        o_rsp_error;
    logic        o_request;
    logic        o_write;
    logic        i_busy = 1'b0;
    logic        i_ack = 1'b0;
    logic [10:0] o_address;
    logic [31:0] o_data;
    logic [31:0] i_data = 32'd0;

    int n_checks = 0;
    int n_fail = 0;

    cart_bus_initiator #(.TIMEOUT_CYCLES(TMO), .ERROR_DATA(ERR_WORD)) dut (
        .i_clk(i_clk), .i_reset_n(i_reset_n),
        .i_cmd_valid(i_cmd_valid), .o_cmd_ready(o_cmd_ready),
        .i_cmd_write(i_cmd_write), .i_cmd_address(i_cmd_address), .i_cmd_data(i_cmd_data),
        .o_rsp_valid(o_rsp_valid), .o_rsp_data(o_rsp_data), .o_rsp_error(o_rsp_error),
        .o_request(o_request), .o_write(o_write), .i_busy(i_busy), .i_ack(i_ack),
        .o_address(o_address), .o_data(o_data), .i_data(i_data)
    );

    always #5 i_clk = ~i_clk;

    task automatic test_reset();
        i_reset_n = 1'b0;
        repeat (3) @(negedge i_clk);
        n_checks++;
        if ({o_cmd_ready, o_request, o_write, o_rsp_valid, o_rsp_error} !== 5'b0 ||
            o_address !== 11'd0 || o_data !== 32'd0 || o_rsp_data !== 32'd0) begin
            n_fail++;
            $display("FAIL reset_values: rdy=%b req=%b wr=%b rv=%b err=%b addr=%h data=%h rdata=%h, required all 0",
                     o_cmd_ready, o_request, o_write, o_rsp_valid, o_rsp_error, o_address, o_data, o_rsp_data);
        end
        i_reset_n = 1'b1;
        #1;
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_before_edge: got %b required 0", o_cmd_ready); end
        @(negedge i_clk);
        n_checks++;
        if (o_cmd_ready !== 1'b1 || o_request !== 1'b0) begin
            n_fail++;
            $display("FAIL ready_after_release: rdy=%b req=%b required rdy=1 req=0", o_cmd_ready, o_request);
        end
    endtask

    // One command against a scripted target: busy_n busy cycles, ack ack_d cycles into WAIT_ACK.
    task automatic do_txn(input bit wr, input logic [10:0] addr, input logic [31:0] wdata,
                          input int busy_n, input int ack_d, input logic [31:0] rdata, input bit hold);
        int exp_rsp, last_req, guard;
        bit tmo, exp_err;
        logic [31:0] exp_data;
        tmo = !wr && TMO_EN && (ack_d >= TMO);
        last_req = busy_n + 1;
        if (wr) exp_rsp = busy_n + 2;
        else if (tmo) exp_rsp = busy_n + 2 + TMO;
        else exp_rsp = busy_n + 3 + ack_d;
        exp_data = wr ? 32'd0 : (tmo ? ERR_WORD : rdata);
        exp_err = tmo;
        i_cmd_valid = 1'b1; i_cmd_write = wr; i_cmd_address = addr; i_cmd_data = wdata;
        i_busy = (busy_n > 0); i_ack = 1'b0;
        guard = 0;
        while (!o_cmd_ready && guard < 50) begin @(negedge i_clk); guard++; end
        if (!o_cmd_ready) begin
            n_checks++; n_fail++;
            $display("FAIL ready_wait: o_cmd_ready stayed %b, required 1 within 50 cycles", o_cmd_ready);
            i_cmd_valid = 1'b0;
        end else begin
            @(posedge i_clk);
            for (int k = 1; k <= exp_rsp + 1; k++) begin
                @(negedge i_clk);
                if (k == 1 && !hold) begin
                    i_cmd_valid = 1'b0;
                    i_cmd_write = 1'($urandom); i_cmd_address = 11'($urandom); i_cmd_data = $urandom;
                end
                n_checks++;
                if (o_request !== (k <= last_req)) begin
                    n_fail++; $display("FAIL request cycle %0d: got %b required %b", k, o_request, (k <= last_req));
                end
                if (k <= last_req) begin
                    n_checks++;
                    if (o_write !== wr || o_address !== addr || o_data !== wdata) begin
                        n_fail++;
                        $display("FAIL bus_outputs cycle %0d: wr=%b addr=%h data=%h required wr=%b addr=%h data=%h",
                                 k, o_write, o_address, o_data, wr, addr, wdata);
                    end
                end
                n_checks++;
                if (o_rsp_valid !== (k == exp_rsp)) begin
                    n_fail++; $display("FAIL rsp_valid cycle %0d: got %b required %b", k, o_rsp_valid, (k == exp_rsp));
                end
                if (k == exp_rsp) begin
                    n_checks++;
                    if (o_rsp_data !== exp_data || o_rsp_error !== exp_err) begin
                        n_fail++;
                        $display("FAIL rsp_payload: data=%h err=%b required data=%h err=%b",
                                 o_rsp_data, o_rsp_error, exp_data, exp_err);
                    end
                end
                n_checks++;
                if (o_cmd_ready !== (k == exp_rsp + 1)) begin
                    n_fail++; $display("FAIL cmd_ready cycle %0d: got %b required %b", k, o_cmd_ready, (k == exp_rsp + 1));
                end
                if (k < last_req) i_busy = 1'b1;
                else if (k == last_req) i_busy = 1'b0;
                else i_busy = 1'($urandom);
                if (!wr && k == busy_n + 2 + ack_d) begin
                    i_ack = 1'b1; i_data = rdata;
                end else if (k <= last_req || k >= exp_rsp) begin
                    i_ack = 1'($urandom); i_data = $urandom;
                end else begin
                    i_ack = 1'b0; i_data = $urandom;
                end
            end
            if (!hold) begin
                for (int k = 0; k < 3; k++) begin
                    @(negedge i_clk);
                    n_checks++;
                    if (o_rsp_valid !== 1'b0 || o_request !== 1'b0 || o_cmd_ready !== 1'b1) begin
                        n_fail++;
                        $display("FAIL idle_after_rsp: rv=%b req=%b rdy=%b required 0 0 1", o_rsp_valid, o_request, o_cmd_ready);
                    end
                    i_ack = 1'($urandom); i_data = $urandom; i_busy = 1'($urandom);
                end
                i_ack = 1'b0; i_busy = 1'b0;
            end
        end
    endtask

    task automatic test_directed();
        do_txn(1'b0, 11'h002, $urandom, 0, 0, 32'h5336_3461, 1'b0);
        do_txn(1'b1, 11'h003, 32'h0000_0001, 4, 0, 32'd0, 1'b0);
        do_txn(1'b0, 11'h7FF, 32'h0, 2, 5, 32'hA5A5_0F0F, 1'b0);
    endtask

    task automatic test_back_to_back();
        do_txn(1'b0, 11'h010, 32'h0, 0, 0, 32'h1111_2222, 1'b1);
        do_txn(1'b1, 11'h011, 32'hDEAD_BEEF, 0, 0, 32'd0, 1'b1);
        do_txn(1'b0, 11'h012, 32'h0, 1, 2, 32'h3333_4444, 1'b0);
    endtask

    task automatic test_timeout();
        do_txn(1'b0, 11'h020, 32'h0, 0, 40, 32'h7777_8888, 1'b0);
        do_txn(1'b0, 11'h021, 32'h0, 1, TMO - 1, 32'h0BAD_CAFE, 1'b0);
        do_txn(1'b0, 11'h022, 32'h0, 0, TMO, 32'h1234_5678, 1'b0);
    endtask

    task automatic test_random();
        for (int i = 0; i < 40; i++) begin
            do_txn(1'($urandom), 11'($urandom), $urandom, int'($urandom_range(0, 4)),
                   int'($urandom_range(0, 12)), $urandom, 1'($urandom));
        end
        do_txn(1'b1, 11'h000, 32'h0, 0, 0, 32'd0, 1'b0);
    endtask

    task automatic test_reset_mid(input bit in_wait);
        i_cmd_valid = 1'b1; i_cmd_write = 1'b0; i_cmd_address = 11'h055; i_cmd_data = 32'h0;
        i_busy = 1'b0; i_ack = 1'b0;
        @(posedge i_clk);
        @(negedge i_clk);
        i_cmd_valid = 1'b0;
        i_busy = !in_wait;
        @(negedge i_clk);
        n_checks++;
        if (o_request !== !in_wait) begin n_fail++; $display("FAIL req_before_reset: got %b required %b", o_request, !in_wait); end
        #2 i_reset_n = 1'b0;
        #1;
        n_checks++;
        if (o_request !== 1'b0 || o_rsp_valid !== 1'b0 || o_cmd_ready !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset: req=%b rv=%b rdy=%b required 0 0 0", o_request, o_rsp_valid, o_cmd_ready);
        end
        @(negedge i_clk);
        i_reset_n = 1'b1; i_busy = 1'b0; i_ack = 1'b1; i_data = $urandom;
        #1;
        n_checks++;
        if (o_cmd_ready !== 1'b0) begin n_fail++; $display("FAIL ready_at_release: got %b required 0", o_cmd_ready); end
        for (int k = 1; k <= 4; k++) begin
            @(negedge i_clk);
            n_checks++;
            if (o_rsp_valid !== 1'b0 || o_request !== 1'b0 || o_cmd_ready !== 1'b1) begin
                n_fail++;
                $display("FAIL after_reset cycle %0d: rv=%b req=%b rdy=%b required 0 0 1", k, o_rsp_valid, o_request, o_cmd_ready);
            end
            i_ack = 1'($urandom); i_data = $urandom;
        end
        i_ack = 1'b0;
    endtask

    initial begin
        test_reset();
        test_directed();
        test_back_to_back();
        test_timeout();
        test_random();
        test_reset_mid(1'b1);
        test_reset_mid(1'b0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
